// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  // Responder sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Active-low byte-lane write-enable encodings
  localparam logic [3:0]  WREN_NONE = 4'b1111;
  localparam logic [3:0]  WREN_WORD = 4'b0000;
  localparam logic [3:0]  WREN_HALF = 4'b1100;
  localparam logic [3:0]  WREN_BYTE = 4'b1110;

  // Data returned for any access outside the implemented range
  localparam logic [31:0] ERR_DATA  = 32'hffffffff;

  // Byte-wise merge: a lane whose active-low enable is 0 takes the new byte,
  // every other lane keeps the old byte. Works for any enable pattern.
  function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  wren_n);
    logic [31:0] result;
    result = 32'h0;
    for (int i = 0; i < 4; i++) begin
      result[8*i +: 8] = wren_n[i] ? old_word[8*i +: 8] : new_word[8*i +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous-read RAM, 2^ADDR_W x 32, per-byte active-high
// write enables. Contents are never reset.
module dmem_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  // Byte-masked write and registered read (read returns the pre-write word)
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Request/response front end for a word-addressed data memory. Loads and
// partial stores take a read cycle (FETCH) before responding; word stores
// write on acceptance and respond on the next cycle.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] addr,
  input  logic [3:0]  wren,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);

  state_t            state;
  logic [ADDR_W-1:0] idx_r;
  logic [3:0]        wren_r;
  logic [31:0]       wdata_r;
  logic              err_r;

  logic              accept;
  logic              req_oor;
  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic [31:0]       merged;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  // Out of range when an address bit above the word index is set (no aliasing).
  assign req_oor   = ((addr >> ADDR_W) != 32'd0);
  // For a load wren_r is all ones, so the merge simply passes the read word.
  assign merged    = merge_word(ram_rdata, wdata_r, wren_r);

  // RAM port steering: request address in IDLE, latched address in FETCH
  always_comb begin
    ram_addr  = addr[ADDR_W-1:0];
    ram_wdata = wdata;
    ram_be    = 4'b0000;
    if (state == FETCH) begin
      ram_addr  = idx_r;
      ram_wdata = merged;
      ram_be    = err_r ? 4'b0000 : ~wren_r;
    end else begin
      if (accept && (wren == WREN_WORD) && !req_oor) begin
        ram_be = 4'b1111;
      end else begin
        ram_be = 4'b0000;
      end
    end
  end

  dmem_ram #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .addr (ram_addr),
    .be   (ram_be),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  // Sequencing FSM with registered response outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      idx_r     <= '0;
      wren_r    <= WREN_NONE;
      wdata_r   <= 32'h0;
      err_r     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rsp_valid <= 1'b0;
          if (accept) begin
            idx_r   <= addr[ADDR_W-1:0];
            wren_r  <= wren;
            wdata_r <= wdata;
            err_r   <= req_oor;
            if (wren == WREN_WORD) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_data  <= req_oor ? ERR_DATA : wdata;
              rsp_err   <= req_oor;
            end else begin
              state <= FETCH;
            end
          end else begin
            state <= IDLE;
          end
        end
        FETCH: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_data  <= err_r ? ERR_DATA : merged;
          rsp_err   <= err_r;
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed, scoreboard-based bench for dmem_responder.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic        clk;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic [3:0]  wren;
  logic [31:0] wdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   rsp_count = 0;
  int   rsp_edge = 0;

  dmem_responder #(.ADDR_W(10)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .addr     (addr),
    .wren     (wren),
    .wdata    (wdata),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Response monitor: pops the scoreboard on every response pulse
  always @(negedge clk) begin
    if (rstn === 1'b1 && rsp_valid === 1'b1) begin
      rsp_count++;
      rsp_edge = cyc + 1;
      chk("rsp_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
      end
    end
  end

  // One request: push expectation, wait for acceptance, check busy time and latency
  task automatic issue(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                       input logic [31:0] ed, input logic ee, input int lat, input string tag);
    int   n0, acc, busy;
    logic rd, ok;
    exp_q.push_back({ed, ee});
    n0 = rsp_count;
    ok = 1'b0;
    acc = 0;
    addr = a; wren = w; wdata = d; req_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      rd = req_ready;
      @(posedge clk);
      @(negedge clk);
      if (rd === 1'b1) begin
        ok = 1'b1;
        acc = cyc;
      end
    end
    req_valid = 1'b0;
    addr = $urandom; wren = 4'($urandom); wdata = $urandom;
    chk({tag, "_accept"}, 32'(ok), 32'd1);
    busy = 0;
    while (req_ready !== 1'b1 && busy < 10) begin
      busy++;
      @(negedge clk);
    end
    #2;
    chk({tag, "_busy"}, 32'(busy), 32'(lat));
    chk({tag, "_rsp_count"}, 32'(rsp_count), 32'(n0 + 1));
    chk({tag, "_latency"}, 32'(rsp_edge - acc), 32'(lat));
  endtask

  initial begin
    int   n0;
    int   acc [3];
    int   idx;
    logic rd;
    logic [31:0] b2b_addr [3];
    logic [3:0]  b2b_wren [3];
    logic [31:0] b2b_data [3];

    rstn = 1'b0; req_valid = 1'b0; addr = 32'h0; wren = WREN_NONE; wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset_rsp_data", rsp_data, 32'h0);
    chk("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
    rstn = 1'b1;
    #1;
    chk("reset_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);

    // Word store then load of word 5
    issue(32'd5, WREN_WORD, 32'h11223344, 32'h11223344, 1'b0, 1, "st5");
    issue(32'd5, WREN_NONE, 32'h0, 32'h11223344, 1'b0, 2, "ld5");
    repeat (3) @(negedge clk);
    #2;
    chk("hold_rsp_data", rsp_data, 32'h11223344);
    chk("hold_rsp_valid", {31'b0, rsp_valid}, 32'd0);

    // Byte store into word 7
    issue(32'd7, WREN_WORD, 32'hAABBCCDD, 32'hAABBCCDD, 1'b0, 1, "st7a");
    issue(32'd7, WREN_BYTE, 32'h000000EE, 32'hAABBCCEE, 1'b0, 2, "byte7");
    issue(32'd7, WREN_NONE, 32'h0, 32'hAABBCCEE, 1'b0, 2, "ld7a");

    // Halfword store into word 7: upper wdata bytes ignored
    issue(32'd7, WREN_WORD, 32'hAABBCCDD, 32'hAABBCCDD, 1'b0, 1, "st7b");
    issue(32'd7, WREN_HALF, 32'hFFFF1234, 32'hAABB1234, 1'b0, 2, "half7");
    issue(32'd7, WREN_NONE, 32'h0, 32'hAABB1234, 1'b0, 2, "ld7b");

    // Irregular lane pattern 0110 writes bytes 0 and 3 only
    issue(32'd7, 4'b0110, 32'h11223344, 32'h11BB1244, 1'b0, 2, "odd7");

    // Inputs toggling without req_valid must be ignored
    for (int i = 0; i < 4; i++) begin
      addr = 32'd7; wren = WREN_WORD; wdata = $urandom; req_valid = 1'b0;
      @(negedge clk);
    end
    #2;
    issue(32'd7, WREN_NONE, 32'h0, 32'h11BB1244, 1'b0, 2, "ld7c");

    // Out-of-range accesses leave word 0 alone
    issue(32'd0, WREN_WORD, 32'h01020304, 32'h01020304, 1'b0, 1, "st0");
    issue(32'h00000400, WREN_NONE, 32'h0, ERR_DATA, 1'b1, 2, "oor_ld");
    issue(32'h00000400, WREN_WORD, 32'hDEADBEEF, ERR_DATA, 1'b1, 1, "oor_st");
    issue(32'h00000400, WREN_BYTE, 32'h000000AA, ERR_DATA, 1'b1, 2, "oor_byte");
    issue(32'd0, WREN_NONE, 32'h0, 32'h01020304, 1'b0, 2, "ld0");

    // Reset during FETCH cancels the merge write
    issue(32'd3, WREN_WORD, 32'h0, 32'h0, 1'b0, 1, "st3");
    issue(32'd5, WREN_NONE, 32'h0, 32'h11223344, 1'b0, 2, "ld5b");
    n0 = rsp_count;
    addr = 32'd3; wren = WREN_BYTE; wdata = 32'h55; req_valid = 1'b1;
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    rstn = 1'b0;
    #1;
    chk("rstf_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rstf_rsp_data", rsp_data, 32'h0);
    chk("rstf_rsp_err", {31'b0, rsp_err}, 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk("rstf_no_rsp", 32'(rsp_count), 32'(n0));
    chk("rstf_ready", {31'b0, req_ready}, 32'd1);
    issue(32'd3, WREN_NONE, 32'h0, 32'h0, 1'b0, 2, "ld3");

    // Back-to-back requests with req_valid held high
    b2b_addr[0] = 32'd20; b2b_wren[0] = WREN_WORD; b2b_data[0] = 32'hCAFEF00D;
    b2b_addr[1] = 32'd20; b2b_wren[1] = WREN_NONE; b2b_data[1] = 32'h0;
    b2b_addr[2] = 32'd21; b2b_wren[2] = WREN_WORD; b2b_data[2] = 32'h12345678;
    exp_q.push_back({32'hCAFEF00D, 1'b0});
    exp_q.push_back({32'hCAFEF00D, 1'b0});
    exp_q.push_back({32'h12345678, 1'b0});
    n0 = rsp_count;
    idx = 0;
    acc[0] = 0; acc[1] = 0; acc[2] = 0;
    for (int c = 0; c < 30 && idx < 3; c++) begin
      addr = b2b_addr[idx]; wren = b2b_wren[idx]; wdata = b2b_data[idx]; req_valid = 1'b1;
      rd = req_ready;
      @(posedge clk);
      @(negedge clk);
      if (rd === 1'b1) begin
        acc[idx] = cyc;
        idx++;
      end
    end
    req_valid = 1'b0;
    for (int c = 0; c < 15 && rsp_count < n0 + 3; c++) @(negedge clk);
    repeat (2) @(negedge clk);
    #2;
    chk("b2b_accepted", 32'(idx), 32'd3);
    chk("b2b_edge1", 32'(acc[1] - acc[0]), 32'd2);
    chk("b2b_edge2", 32'(acc[2] - acc[0]), 32'd5);
    chk("b2b_rsp_count", 32'(rsp_count), 32'(n0 + 3));
    issue(32'd21, WREN_NONE, 32'h0, 32'h12345678, 1'b0, 2, "ld21");

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
